road_obstacle_spawner: RTL



---
 rtl/road_pkg.sv | 20 ++
 rtl/free_slot_finder.sv | 23 ++
 rtl/road_obstacle_spawner.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/road_pkg.sv
// Shared types and widths for the road obstacle spawner slice.
package road_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned RAND_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        PLACE
    } spawn_state_t;

    typedef struct packed {
        logic               active;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } obstacle_t;

endpackage

// File: rtl/free_slot_finder.sv
// Combinational priority encoder: lowest-index slot whose active flag is clear.
module free_slot_finder #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic [NUM_SLOTS-1:0] active,
    output logic [IDX_W-1:0]     free_idx,
    output logic                 found
);

    // Scan from the top down so the last hit (lowest index) wins.
    always_comb begin
        found    = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                found    = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/road_obstacle_spawner.sv
// Spawns obstacles from the road RNG into a slot pool and scrolls them once per frame.
// Optional SPAWN_DROP_CNT_EN adds a saturating drop_cnt output counting spawns lost to a full pool.
module road_obstacle_spawner
    import road_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = 4,
    parameter int unsigned SPAWN_FRAMES = 60,
    parameter int unsigned ROAD_LEFT    = 192,
    parameter int unsigned X_SHIFT      = 2,
    parameter int unsigned SPAWN_Y      = 0,
    parameter int unsigned SCREEN_H     = 480
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic                         game_on,
    input  logic [3:0]                   speed,
    input  logic [RAND_W-1:0]            rand_val,
    input  logic [NUM_SLOTS-1:0]         clear_slot,
    output logic                         rand_req,
    output logic [NUM_SLOTS-1:0]         obj_active,
`ifdef SPAWN_DROP_CNT_EN
    output logic [7:0]                   drop_cnt,
`endif
    output logic [NUM_SLOTS*COORD_W-1:0] obj_x,
    output logic [NUM_SLOTS*COORD_W-1:0] obj_y
);

    localparam int unsigned CNT_W = ($clog2(SPAWN_FRAMES) > 6) ? $clog2(SPAWN_FRAMES) : 6;
    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    spawn_state_t       state_q, state_d;
    logic               rand_req_q, rand_req_d;
    obstacle_t          slot_q [NUM_SLOTS];
    obstacle_t          slot_d [NUM_SLOTS];
    logic [COORD_W:0]   y_next [NUM_SLOTS];
    logic               frame_tick;
    logic               spawn_due;
    logic [IDX_W-1:0]   free_idx;
    logic               free_found;
    logic [COORD_W-1:0] spawn_x;

    assign frame_tick = startOfFrame & game_on;
    assign spawn_due  = frame_tick && (frame_cnt_q == CNT_W'(SPAWN_FRAMES - 1));
    assign spawn_x    = COORD_W'(ROAD_LEFT) + (COORD_W'(rand_val) << X_SHIFT);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
            frame_cnt_d = spawn_due ? '0 : frame_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (spawn_due) state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT:    state_d = PLACE;
            PLACE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Registered so the generator sees a glitch-free one-cycle pulse.
        rand_req_d = (state_d == REQ);
    end

    free_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_free_slot_finder (
        .active   (obj_active),
        .free_idx (free_idx),
        .found    (free_found)
    );

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            y_next[i] = {1'b0, slot_q[i].y} + (COORD_W + 1)'(speed);
            if (slot_q[i].active) begin
                if (clear_slot[i]) begin
                    slot_d[i].active = 1'b0;
                end else if (frame_tick) begin
                    if (y_next[i] >= (COORD_W + 1)'(SCREEN_H)) begin
                        slot_d[i].active = 1'b0;
                    end else begin
                        slot_d[i].y = y_next[i][COORD_W-1:0];
                    end
                end
            end
        end
        // The chosen slot is inactive, so it was untouched by scroll/clear above.
        if ((state_q == PLACE) && free_found) begin
            slot_d[free_idx] = '{active: 1'b1, x: spawn_x, y: COORD_W'(SPAWN_Y)};
        end
    end

    always_comb begin
        obj_active = '0;
        obj_x      = '0;
        obj_y      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            obj_active[i]                 = slot_q[i].active;
            obj_x[i*COORD_W +: COORD_W]   = slot_q[i].x;
            obj_y[i*COORD_W +: COORD_W]   = slot_q[i].y;
        end
    end

    assign rand_req = rand_req_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_q <= '0;
            state_q     <= IDLE;
            rand_req_q  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
            rand_req_q  <= rand_req_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

`ifdef SPAWN_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((state_q == PLACE) && !free_found && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
